// File: rtl/bus_arbiter_if.sv
// bus_arbiter_if
//   One memory-bus handshake bundle. The same bundle describes a cache-side
//   requester port and the core-side bus port.
//   master : drives request beats and response acks (a cache controller,
//            or the arbiter towards the core bus)
//   slave  : accepts request beats and produces response beats (the core
//            bus, or the arbiter towards a cache controller)
//   Signals:
//     reqcyc/req/reqtag : request beat valid, address or data, tag
//     reqack            : request beat accepted
//     respcyc/resp/resptag : response beat valid, data, tag
//     respack           : response beat accepted
interface bus_arbiter_if #(
  parameter int DATA_WIDTH = 64,
  parameter int TAG_WIDTH  = 13
);
  logic                  reqcyc;
  logic [DATA_WIDTH-1:0] req;
  logic [TAG_WIDTH-1:0]  reqtag;
  logic                  respack;
  logic                  reqack;
  logic                  respcyc;
  logic [DATA_WIDTH-1:0] resp;
  logic [TAG_WIDTH-1:0]  resptag;

  modport master (
    output reqcyc, req, reqtag, respack,
    input  reqack, respcyc, resp, resptag
  );

  modport slave (
    input  reqcyc, req, reqtag, respack,
    output reqack, respcyc, resp, resptag
  );
endinterface

// File: rtl/bus_arbiter.sv
// bus_arbiter
//   Shares the core memory bus between the data cache (port 0) and the
//   instruction cache (port 1). One requester owns the whole bus for one
//   complete transaction (request beats plus, for reads, the response
//   burst). Ties are broken round-robin; ownership only changes in IDLE,
//   so there is always one idle cycle between transactions.
//   Ports:
//     clk   : clock, rising edge
//     reset : asynchronous, active-low reset
//     p0    : data-cache requester (slave side of its bundle)
//     p1    : instruction-cache requester (slave side of its bundle)
//     bus   : core memory bus (master side)
//     grant : one-hot bus owner, 0 while idle
module bus_arbiter #(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH  = 13,
  parameter int BEATS          = 8,
  parameter int WR_BIT         = 12
) (
  input  logic          clk,
  input  logic          reset,
  bus_arbiter_if.slave  p0,
  bus_arbiter_if.slave  p1,
  bus_arbiter_if.master bus,
  output logic [1:0]    grant
);

  localparam int CW = $clog2(BEATS + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic          owner_q, owner_d;
  logic          last_q, last_d;
  logic          wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Owner-side view of the two requesters.
  logic                      own_reqcyc;
  logic [BUS_DATA_WIDTH-1:0] own_req;
  logic [BUS_TAG_WIDTH-1:0]  own_reqtag;
  logic                      own_respack;
  logic                      is_write;
  logic                      req_beat;
  logic                      resp_beat;

  always_comb begin
    own_reqcyc  = owner_q ? p1.reqcyc  : p0.reqcyc;
    own_req     = owner_q ? p1.req     : p0.req;
    own_reqtag  = owner_q ? p1.reqtag  : p0.reqtag;
    own_respack = owner_q ? p1.respack : p0.respack;
    // The direction comes from the live tag on the first beat only; later
    // write beats use the copy captured then.
    is_write    = (cnt_q == '0) ? own_reqtag[WR_BIT] : wr_q;
    req_beat    = own_reqcyc & bus.reqack;
    resp_beat   = bus.respcyc & own_respack;
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;  // port 0 wins the first tie
      wr_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      wr_q    <= wr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    wr_d    = wr_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (p0.reqcyc | p1.reqcyc) begin
          // A tie goes to the port that was not served last.
          owner_d = (p0.reqcyc & p1.reqcyc) ? ~last_q : p1.reqcyc;
          last_d  = owner_d;
          cnt_d   = '0;
          state_d = REQ;
        end
      end
      REQ: begin
        if (req_beat) begin
          if (cnt_q == '0) begin
            wr_d = own_reqtag[WR_BIT];
          end
          if (!is_write) begin
            state_d = RESP;
            cnt_d   = '0;
          end else if (cnt_q == CW'(BEATS)) begin
            // address beat plus BEATS data beats are done
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      RESP: begin
        if (resp_beat) begin
          if (cnt_q == CW'(BEATS - 1)) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic: everything is steered from the registered state, so an
  // asynchronous reset clears every output immediately.
  always_comb begin
    grant       = 2'b00;
    bus.reqcyc  = 1'b0;
    bus.req     = '0;
    bus.reqtag  = '0;
    bus.respack = 1'b0;
    p0.reqack   = 1'b0;
    p0.respcyc  = 1'b0;
    p0.resp     = '0;
    p0.resptag  = '0;
    p1.reqack   = 1'b0;
    p1.respcyc  = 1'b0;
    p1.resp     = '0;
    p1.resptag  = '0;
    unique case (state_q)
      REQ: begin
        grant      = owner_q ? 2'b10 : 2'b01;
        bus.reqcyc = own_reqcyc;
        bus.req    = own_req;
        bus.reqtag = own_reqtag;
        if (owner_q) begin
          p1.reqack = bus.reqack;
        end else begin
          p0.reqack = bus.reqack;
        end
      end
      RESP: begin
        grant       = owner_q ? 2'b10 : 2'b01;
        bus.respack = own_respack;
        // Data and tag are broadcast; only respcyc marks the owner.
        p0.resp     = bus.resp;
        p0.resptag  = bus.resptag;
        p1.resp     = bus.resp;
        p1.resptag  = bus.resptag;
        if (owner_q) begin
          p1.respcyc = bus.respcyc;
        end else begin
          p0.respcyc = bus.respcyc;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_bus_arbiter.sv
module tb_bus_arbiter;
  localparam int DW     = 64;
  localparam int TW     = 13;
  localparam int BEATS  = 8;
  localparam int WR_BIT = 12;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] grant;

  always #5 clk = ~clk;

  bus_arbiter_if #(.DATA_WIDTH(DW), .TAG_WIDTH(TW)) p0_if ();
  bus_arbiter_if #(.DATA_WIDTH(DW), .TAG_WIDTH(TW)) p1_if ();
  bus_arbiter_if #(.DATA_WIDTH(DW), .TAG_WIDTH(TW)) bus_if ();

  bus_arbiter #(
    .BUS_DATA_WIDTH(DW),
    .BUS_TAG_WIDTH (TW),
    .BEATS         (BEATS),
    .WR_BIT        (WR_BIT)
  ) dut (
    .clk  (clk),
    .reset(rst_n),
    .p0   (p0_if),
    .p1   (p1_if),
    .bus  (bus_if),
    .grant(grant)
  );

  typedef struct {
    bit         set0;
    bit         wr0;
    bit         set1;
    bit         wr1;
    int         ack_dly;
    int         stall_beat;
    int         stall_len;
    logic [1:0] exp_grant;
  } vec_t;

  typedef struct {
    int          port;
    logic [63:0] data;
    logic [12:0] tag;
  } resp_t;

  int          errors = 0;
  int          checks = 0;
  bit          pend [2];
  bit          wr   [2];
  logic [63:0] addr [2];
  logic [12:0] tag  [2];
  int          beat [2];
  logic [1:0]  exp_grant_q [$];
  resp_t       resp_q [$];
  vec_t        vecs [9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic get_reqack(input int p);
    return (p == 1) ? p1_if.reqack : p0_if.reqack;
  endfunction

  function automatic logic get_respcyc(input int p);
    return (p == 1) ? p1_if.respcyc : p0_if.respcyc;
  endfunction

  function automatic logic [63:0] get_resp(input int p);
    return (p == 1) ? p1_if.resp : p0_if.resp;
  endfunction

  function automatic logic [12:0] get_resptag(input int p);
    return (p == 1) ? p1_if.resptag : p0_if.resptag;
  endfunction

  function automatic logic [63:0] req_val(input int p, input int b);
    return (b == 0) ? addr[p] : {32'hDA7A_0000, 16'(p), 16'(b)};
  endfunction

  task automatic set_respack(input int p, input logic v);
    if (p == 1) p1_if.respack = v;
    else        p0_if.respack = v;
  endtask

  task automatic drive_req(input int p);
    if (p == 1) begin
      p1_if.reqcyc = pend[1];
      p1_if.req    = pend[1] ? req_val(1, beat[1]) : 64'h0;
      p1_if.reqtag = pend[1] ? tag[1] : 13'h0;
    end else begin
      p0_if.reqcyc = pend[0];
      p0_if.req    = pend[0] ? req_val(0, beat[0]) : 64'h0;
      p0_if.reqtag = pend[0] ? tag[0] : 13'h0;
    end
  endtask

  task automatic raise(input int p, input bit w, input int id);
    pend[p] = 1'b1;
    wr[p]   = w;
    addr[p] = 64'h1000 + (64'(id) << 16) + (p == 0 ? 64'h100 : 64'h0);
    tag[p]  = {w, 12'(id * 2 + p)};
    beat[p] = 0;
    drive_req(p);
  endtask

  // Acts as the core-side bus for one granted transaction.
  task automatic serve(input int vi, input int ack_dly, input int stall_beat,
                       input int stall_len, input int exp_wait, input int rst_beat,
                       input bit raise_p0);
    int         own;
    int         other;
    int         waited;
    int         nbeats;
    int         delivered;
    bit         ack;
    logic [1:0] eg;
    resp_t      r;
    waited = 0;
    do begin
      @(negedge clk);
      #1;
      waited++;
    end while (grant == 2'b00 && waited < 40);
    chk("grant_wait", 64'(waited), 64'(exp_wait));
    if (grant == 2'b00) return;
    eg = exp_grant_q.pop_front();
    chk("grant", grant, eg);
    own   = grant[1] ? 1 : 0;
    other = 1 - own;
    $display("txn %0d: grant=%b port %0d %s", vi, grant, own, wr[own] ? "write" : "read");
    if (raise_p0) raise(0, 1'b0, vi);
    nbeats = wr[own] ? BEATS + 1 : 1;
    for (int b = 0; b < nbeats; b++) begin
      for (int d = 0; d < ack_dly; d++) begin
        @(negedge clk);
        bus_if.respcyc = wr[own];  // stray response during a write must not leak
        #1;
        chk("reqack_wait", get_reqack(own), 0);
        chk("stray_resp", get_respcyc(own), 0);
      end
      @(negedge clk);
      bus_if.reqack  = 1'b1;
      bus_if.respcyc = 1'b0;
      #1;
      chk("bus_reqcyc", bus_if.reqcyc, 1);
      chk("bus_req", bus_if.req, req_val(own, b));
      chk("bus_reqtag", bus_if.reqtag, tag[own]);
      chk("reqack_own", get_reqack(own), 1);
      chk("reqack_other", get_reqack(other), 0);
      @(posedge clk);
      #1;
      bus_if.reqack = 1'b0;
      beat[own]++;
      if (b == nbeats - 1) pend[own] = 1'b0;
      drive_req(own);
    end
    if (wr[own]) begin
      chk("write_idle", grant, 0);
      return;
    end
    delivered = 0;
    for (int k = 0; k < BEATS; k++) begin
      if (k == rst_beat) begin
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_grant", grant, 0);
        chk("rst_respcyc", get_respcyc(own), 0);
        chk("rst_resp", get_resp(own), 0);
        chk("rst_respack", bus_if.respack, 0);
        chk("rst_reqcyc", bus_if.reqcyc, 0);
        pend[own] = 1'b0;
        drive_req(own);
        set_respack(own, 1'b0);
        bus_if.respcyc = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_hold_grant", grant, 0);
        return;
      end
      r.port = own;
      r.data = 64'(k) + (64'(vi) << 32);
      r.tag  = tag[own];
      resp_q.push_back(r);
      for (int s = 0; s <= ((k == stall_beat) ? stall_len : 0); s++) begin
        ack = !(k == stall_beat && s < stall_len);
        @(negedge clk);
        bus_if.respcyc = 1'b1;
        bus_if.resp    = r.data;
        bus_if.resptag = r.tag;
        set_respack(own, ack);
        #1;
        chk("grant_hold", grant, eg);
        chk("respack_fwd", bus_if.respack, ack);
        chk("respcyc_own", get_respcyc(own), 1);
        chk("respcyc_other", get_respcyc(other), 0);
        if (!ack) chk("cnt_hold", dut.cnt_q, 64'(k));
        if (ack) begin
          r = resp_q.pop_front();
          chk("resp_data", get_resp(r.port), r.data);
          chk("resp_tag", get_resptag(r.port), r.tag);
          delivered++;
        end
      end
    end
    @(posedge clk);
    #1;
    bus_if.respcyc = 1'b0;
    set_respack(own, 1'b0);
    chk("resp_idle", grant, 0);
    chk("resp_beats", 64'(delivered), 64'(BEATS));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // set0 wr0 set1 wr1 ack stall_beat stall_len exp_grant
    vecs[0] = '{1, 0, 1, 0, 1, -1, 0, 2'b01};  // tie after reset: port 0
    vecs[1] = '{0, 0, 0, 0, 1, -1, 0, 2'b10};  // then the waiting port 1
    vecs[2] = '{0, 0, 1, 0, 2, -1, 0, 2'b10};  // single read from port 1
    vecs[3] = '{1, 0, 1, 0, 0, -1, 0, 2'b01};  // fairness 0,1,0,1
    vecs[4] = '{1, 0, 0, 0, 0, -1, 0, 2'b10};
    vecs[5] = '{0, 0, 1, 0, 0, -1, 0, 2'b01};
    vecs[6] = '{0, 0, 0, 0, 0, -1, 0, 2'b10};
    vecs[7] = '{1, 1, 0, 0, 1, -1, 0, 2'b01};  // write, stall between beats
    vecs[8] = '{0, 0, 1, 0, 0, 4, 3, 2'b10};   // response backpressure

    rst_n = 1'b0;
    for (int p = 0; p < 2; p++) begin
      pend[p] = 1'b0;
      beat[p] = 0;
      drive_req(p);
      set_respack(p, 1'b0);
    end
    bus_if.reqack  = 1'b0;
    bus_if.respcyc = 1'b0;
    bus_if.resp    = 64'h0;
    bus_if.resptag = 13'h0;
    #1;
    chk("reset_grant", grant, 0);
    chk("reset_bus_reqcyc", bus_if.reqcyc, 0);
    chk("reset_bus_respack", bus_if.respack, 0);
    repeat (3) @(negedge clk);
    chk("reset_last", dut.last_q, 1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int vi = 0; vi < 9; vi++) begin
      if (vecs[vi].set0) raise(0, vecs[vi].wr0, vi);
      if (vecs[vi].set1) raise(1, vecs[vi].wr1, vi);
      exp_grant_q.push_back(vecs[vi].exp_grant);
      serve(vi, vecs[vi].ack_dly, vecs[vi].stall_beat, vecs[vi].stall_len, 2, -1, 1'b0);
    end

    // A response beat in IDLE is not forwarded.
    bus_if.respcyc = 1'b1;
    bus_if.resp    = 64'h5A5A;
    p1_if.respack  = 1'b1;
    @(negedge clk);
    #1;
    chk("idle_respcyc0", p0_if.respcyc, 0);
    chk("idle_respcyc1", p1_if.respcyc, 0);
    chk("idle_respack", bus_if.respack, 0);
    chk("idle_grant", grant, 0);
    bus_if.respcyc = 1'b0;
    p1_if.respack  = 1'b0;
    @(posedge clk);
    #1;

    // Reset in the middle of a port-1 read while port 0 waits.
    raise(1, 1'b0, 20);
    exp_grant_q.push_back(2'b10);
    serve(20, 0, -1, 0, 2, 3, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    exp_grant_q.push_back(2'b01);
    serve(21, 0, -1, 0, 1, -1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Two-port arbiter that shares the core's single memory-bus interface between the instruction cache (port 1) and the data cache (port 0). It sits between the two cache controllers and the top-level bus_* ports of the core. It grants the whole bus to one requester for one complete transaction: request phase plus, for reads, the full response burst. It arbitrates round-robin and returns to idle between transactions.

## Interface
Parameters:
- BUS_DATA_WIDTH, 64, bus data width
- BUS_TAG_WIDTH, 13, bus tag width
- BEATS, 8, data beats per line transfer (64-byte line)
- WR_BIT, 12, tag bit that marks a write transaction (1 = write)

Ports:
- clk  in  1  single clock; everything is sampled on its rising edge
- reset  in  1  asynchronous, active-low reset
- pN_reqcyc  in  1  requester N (N = 0, 1) drives a request beat
- pN_req  in  BUS_DATA_WIDTH  requester N request address or data
- pN_reqtag  in  BUS_TAG_WIDTH  requester N request tag
- pN_respack  in  1  requester N accepts a response beat
- pN_reqack  out  1  bus accepted requester N's request beat
- pN_respcyc  out  1  response beat is valid for requester N
- pN_resp  out  BUS_DATA_WIDTH  response data, forwarded to requester N
- pN_resptag  out  BUS_TAG_WIDTH  response tag, forwarded to requester N
- bus_reqcyc, bus_req, bus_reqtag, bus_respack  out  1/DW/TW/1  bus-side request
- bus_reqack, bus_respcyc, bus_resp, bus_resptag  in  1/1/DW/TW  bus-side response
- grant  out  2  one-hot owner of the bus (bit N = port N); 0 when idle

## Operation
- State machine: IDLE, REQ, RESP. A 1-bit register `owner` and a 1-bit register `last` (last port granted) hold the arbitration state. A beat counter `cnt` is clog2(BEATS+1) bits wide.
- IDLE: if exactly one pN_reqcyc is high, grant that port. If both are high, grant port !last. On grant: owner<=N, last<=N, cnt<=0, state goes to REQ. With no requests, stay in IDLE.
- REQ: the bus_req* signals equal the owner's pN_req*. Only the owner sees bus_reqack on its pN_reqack.
  - Read (owner tag[WR_BIT]=0): after 1 accepted beat (reqcyc&reqack), go to RESP with cnt<=0.
  - Write (owner tag[WR_BIT]=1): each accepted beat increments cnt. After the accepted beat with cnt==BEATS (address plus BEATS data beats, BEATS+1 beats total), go to IDLE.
  - The tag is sampled on the first beat and held in a register for the rest of the transaction.
- RESP: bus_respcyc, bus_resp and bus_resptag are forwarded only to the owner. The non-owner's pN_respcyc is 0. bus_respack equals the owner's pN_respack. Each beat with respcyc&respack increments cnt. On the beat with cnt==BEATS-1, go to IDLE.
- A non-owner's pN_reqack and pN_respcyc are always 0. Its request is held off until a later IDLE.
- The pN_resp and pN_resptag data buses may be broadcast to both ports. Only pN_respcyc qualifies them.
- In IDLE: bus_reqcyc=0, bus_respack=0, grant=0.
- Reset (asserted low, at any time, including mid-burst): state=IDLE, grant=0, last=1 (so port 0 wins the first tie), cnt=0, all outputs 0. No transaction is resumed after reset.

## Timing
- Grant latency: a request first seen high in IDLE at edge k drives bus_reqcyc in the cycle after edge k, with grant set from edge k.
- Request and response paths are combinational through the mux. There is no added latency per beat.
- Turnaround: after the final beat, the arbiter spends one IDLE cycle before the next grant. Back-to-back transactions therefore have exactly one dead cycle.
- Requesters must hold reqcyc, req and reqtag stable until reqack, per the bus rules. The arbiter does not buffer.
- Ownership switches only in IDLE. Never switch mid-transaction, even if the other port is waiting.
- If bus_respcyc is high while in IDLE or REQ, nothing is forwarded and no beat is counted.

## Test plan
- Single read from port 1: p1 tag[12]=0, address 0x1000, bus acks after 2 cycles, then 8 response beats with data 0..7. Required: p1 sees reqack once and 8 respcyc beats with data 0..7; p0 sees nothing; grant goes 10 then 00 one cycle after the 8th beat.
- Simultaneous requests right after reset: p0 is granted first (grant=01). After its read completes there is 1 IDLE cycle, then p1 is granted (grant=10).
- Fairness: p0 and p1 both request continuously for 4 transactions. Required: grants alternate 0,1,0,1.
- Write from port 0: tag[12]=1, 9 request beats, each acked with a 1-cycle bus stall between beats. Required: 9 reqacks forwarded to p0; state returns to IDLE without entering RESP; no respcyc forwarded.
- Response backpressure: p1 holds respack low for 3 cycles on beat 4. Required: cnt holds during the stall; bus_respack=0 during the stall; 8 beats total are delivered.
- Reset mid-RESP: assert reset low after beat 3. Required: all outputs 0 immediately (asynchronously); grant=00; after reset is released, a pending p0 request is granted first.
